// File: rtl/fsm_lane_checker_pkg.sv
// Shared types and helpers for the multi-lane FSM checker.
// Holds the control state encoding and the saturating increment used by every lane counter.
package fsm_lane_checker_pkg;

  typedef enum logic [1:0] {
    FLUSH = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam int MAX_STEPS_C = 16;

  // Increment cnt unless it already holds the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int width);
    logic [31:0] max_v;
    max_v   = 32'hFFFF_FFFF >> (32 - width);
    sat_inc = (cnt == max_v) ? cnt : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/fsm_lane_counter.sv
// Per-lane saturating mismatch counter with a sticky flag.
// Updates one edge after inc; clear wins over inc; freeze holds both registers.
module fsm_lane_counter
  import fsm_lane_checker_pkg::*;
#(
  parameter int CNT_WIDTH_G = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   inc,
  input  logic                   freeze,
  output logic [CNT_WIDTH_G-1:0] count,
  output logic                   sticky
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count  <= '0;
      sticky <= 1'b0;
    end else if (inc && !freeze) begin
      count  <= CNT_WIDTH_G'(sat_inc(32'(count), CNT_WIDTH_G));
      sticky <= 1'b1;
    end
  end

endmodule

// File: rtl/fsm_lane_checker.sv
// Compares N lane-end FSM outputs against the pattern delayed by the lane depth.
// All outputs registered, 1-cycle latency; optional freeze of all status on first mismatch.
module fsm_lane_checker
  import fsm_lane_checker_pkg::*;
#(
  parameter int IO_SIZE_G       = 3,
  parameter int N_LANES_G       = 4,
  parameter int STEPS_G         = 1,
  parameter int CNT_WIDTH_G     = 16,
  parameter int IDLE            = 0,
  parameter int ERROR           = 7,
  parameter int STOP_ON_ERROR_G = 0
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             enable_i,
  input  logic                             clear_i,
  input  logic [IO_SIZE_G-1:0]             data_pattern_generator_i,
  input  logic [N_LANES_G*IO_SIZE_G-1:0]   data_fsm_i,
  output logic [N_LANES_G-1:0]             error_state_o,
  output logic [N_LANES_G-1:0]             error_mismatch_o,
  output logic [N_LANES_G-1:0]             sticky_mismatch_o,
  output logic [N_LANES_G*CNT_WIDTH_G-1:0] mismatch_count_o,
  output logic                             armed_o,
  output logic                             halted_o
);

  localparam int FW = $clog2(MAX_STEPS_C);

  state_t                state;
  logic [FW-1:0]         flush_cnt;
  logic [IO_SIZE_G-1:0]  dly [STEPS_G];
  logic [IO_SIZE_G-1:0]  exp_dat;
  logic [N_LANES_G-1:0]  mis;
  logic [N_LANES_G-1:0]  est;
  logic                  freeze;

  // The delay line mirrors the lane depth; only reset touches it, clear does not.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < STEPS_G; k++) dly[k] <= IO_SIZE_G'(IDLE);
    end else begin
      dly[0] <= data_pattern_generator_i;
      for (int k = 1; k < STEPS_G; k++) dly[k] <= dly[k-1];
    end
  end

  assign exp_dat = dly[STEPS_G-1];
  assign freeze  = (state == HALT);

  always_comb begin
    mis = '0;
    est = '0;
    for (int i = 0; i < N_LANES_G; i++) begin
      mis[i] = (state == RUN) && enable_i &&
               (data_fsm_i[i*IO_SIZE_G +: IO_SIZE_G] != exp_dat);
      est[i] = enable_i &&
               (data_fsm_i[i*IO_SIZE_G +: IO_SIZE_G] == IO_SIZE_G'(ERROR));
    end
  end

  // armed_o tracks the RUN state, so it drops when the checker halts.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state            <= FLUSH;
      flush_cnt        <= '0;
      armed_o          <= 1'b0;
      halted_o         <= 1'b0;
      error_mismatch_o <= '0;
      error_state_o    <= '0;
    end else begin
      case (state)
        FLUSH: begin
          error_mismatch_o <= mis;
          error_state_o    <= est;
          if (flush_cnt == FW'(STEPS_G - 1)) begin
            state   <= RUN;
            armed_o <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        RUN: begin
          error_mismatch_o <= mis;
          error_state_o    <= est;
          if ((STOP_ON_ERROR_G != 0) && (|mis)) begin
            state    <= HALT;
            armed_o  <= 1'b0;
            halted_o <= 1'b1;
          end
        end
        HALT: begin
        end
        default: begin
          state     <= FLUSH;
          flush_cnt <= '0;
          armed_o   <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < N_LANES_G; g++) begin : g_lane
    fsm_lane_counter #(
      .CNT_WIDTH_G(CNT_WIDTH_G)
    ) u_cnt (
      .clk    (clk_i),
      .rst    (rst_i),
      .clear  (clear_i),
      .inc    (mis[g]),
      .freeze (freeze),
      .count  (mismatch_count_o[g*CNT_WIDTH_G +: CNT_WIDTH_G]),
      .sticky (sticky_mismatch_o[g])
    );
  end

endmodule

// File: tb/tb_fsm_lane_checker.sv
// Scoreboard bench: directed stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_fsm_lane_checker;

  localparam int IO = 3;
  localparam int N  = 4;
  localparam int CW = 4;

  localparam int K_ARM = 0;
  localparam int K_HLT = 1;
  localparam int K_MIS = 2;
  localparam int K_EST = 3;
  localparam int K_STK = 4;
  localparam int K_CNT = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [IO-1:0]   pat;
  logic            en;
  logic            rst_a, clr_a, rst_b, clr_b;
  logic [N*IO-1:0] data_a, data_b;

  logic [N-1:0]    es_a, em_a, st_a, es_b, em_b, st_b;
  logic [N*CW-1:0] cnt_a, cnt_b;
  logic            armed_a, halted_a, armed_b, halted_b;

  fsm_lane_checker #(
    .IO_SIZE_G(IO), .N_LANES_G(N), .STEPS_G(2), .CNT_WIDTH_G(CW),
    .IDLE(0), .ERROR(7), .STOP_ON_ERROR_G(0)
  ) dut_a (
    .clk_i(clk), .rst_i(rst_a), .enable_i(en), .clear_i(clr_a),
    .data_pattern_generator_i(pat), .data_fsm_i(data_a),
    .error_state_o(es_a), .error_mismatch_o(em_a), .sticky_mismatch_o(st_a),
    .mismatch_count_o(cnt_a), .armed_o(armed_a), .halted_o(halted_a)
  );

  fsm_lane_checker #(
    .IO_SIZE_G(IO), .N_LANES_G(N), .STEPS_G(2), .CNT_WIDTH_G(CW),
    .IDLE(0), .ERROR(7), .STOP_ON_ERROR_G(1)
  ) dut_b (
    .clk_i(clk), .rst_i(rst_b), .enable_i(en), .clear_i(clr_b),
    .data_pattern_generator_i(pat), .data_fsm_i(data_b),
    .error_state_o(es_b), .error_mismatch_o(em_b), .sticky_mismatch_o(st_b),
    .mismatch_count_o(cnt_b), .armed_o(armed_b), .halted_o(halted_b)
  );

  typedef struct {
    int          cyc;
    int          dut;
    int          kind;
    int          lane;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   edges  = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) edges <= edges + 1;

  function automatic logic [31:0] actual(input int dut, input int kind, input int lane);
    logic [31:0] r;
    r = '0;
    case (kind)
      K_ARM: r = 32'(dut != 0 ? armed_b  : armed_a);
      K_HLT: r = 32'(dut != 0 ? halted_b : halted_a);
      K_MIS: r = 32'(dut != 0 ? em_b : em_a);
      K_EST: r = 32'(dut != 0 ? es_b : es_a);
      K_STK: r = 32'(dut != 0 ? st_b : st_a);
      K_CNT: r = 32'(dut != 0 ? cnt_b[lane*CW +: CW] : cnt_a[lane*CW +: CW]);
      default: r = 32'hDEAD_BEEF;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].cyc <= edges) begin
      e   = sb.pop_front();
      act = actual(e.dut, e.kind, e.lane);
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s (edge %0d): got %0h expected %0h", e.name, e.cyc, act, e.val);
      end
    end
  end

  // Expectation for the response to the inputs about to be applied.
  task automatic want(input int dut, input int kind, input int lane,
                      input logic [31:0] v, input string name);
    exp_t e;
    e.cyc  = edges + 1;
    e.dut  = dut;
    e.kind = kind;
    e.lane = lane;
    e.val  = v;
    e.name = name;
    sb.push_back(e);
  endtask

  logic [IO-1:0] ha1 = '0, ha2 = '0, hb1 = '0, hb2 = '0;
  logic [IO-1:0] xa [N];
  logic [IO-1:0] xb [N];
  int            force_lane = -1;
  logic [IO-1:0] force_val  = '0;
  int            pc = 0;

  // Lanes carry the pattern from two cycles back, optionally corrupted per lane.
  task automatic apply();
    pat = IO'(pc % 7);
    pc++;
    for (int i = 0; i < N; i++) begin
      data_a[i*IO +: IO] = ha2 ^ xa[i];
      data_b[i*IO +: IO] = hb2 ^ xb[i];
    end
    if (force_lane >= 0) data_a[force_lane*IO +: IO] = force_val;
    @(posedge clk);
    #1;
    if (rst_a) begin ha1 = '0; ha2 = '0; end
    else begin ha2 = ha1; ha1 = pat; end
    if (rst_b) begin hb1 = '0; hb2 = '0; end
    else begin hb2 = hb1; hb1 = pat; end
  endtask

  initial begin
    en = 1'b1; rst_a = 1'b1; rst_b = 1'b1; clr_a = 1'b0; clr_b = 1'b0;
    pat = '0; data_a = '0; data_b = '0;
    for (int i = 0; i < N; i++) begin xa[i] = '0; xb[i] = '0; end

    apply();
    apply();
    want(0, K_ARM, 0, 0, "reset_armed");
    want(0, K_HLT, 0, 0, "reset_halted");
    want(0, K_MIS, 0, 0, "reset_mismatch");
    want(0, K_EST, 0, 0, "reset_err_state");
    want(0, K_STK, 0, 0, "reset_sticky");
    for (int i = 0; i < N; i++) want(0, K_CNT, i, 0, $sformatf("reset_cnt%0d", i));
    want(1, K_HLT, 0, 0, "reset_halted_b");
    apply();
    rst_a = 1'b0;

    // Lane 1 shows the error encoding while still flushing.
    force_lane = 1; force_val = 3'd7;
    want(0, K_EST, 0, 32'b0010, "flush_err_state");
    want(0, K_MIS, 0, 0, "flush_no_mismatch");
    want(0, K_ARM, 0, 0, "flush_armed_low");
    apply();
    force_lane = -1;
    want(0, K_ARM, 0, 1, "armed_after_2");
    want(0, K_EST, 0, 0, "err_state_drop");
    apply();

    for (int k = 0; k < 100; k++) begin
      want(0, K_MIS, 0, 0, "clean_mismatch");
      if (k % 25 == 0) want(0, K_EST, 0, 0, "clean_err_state");
      apply();
    end
    for (int i = 0; i < N; i++) want(0, K_CNT, i, 0, $sformatf("clean_cnt%0d", i));
    want(0, K_STK, 0, 0, "clean_sticky");
    apply();

    for (int k = 0; k < 3; k++) begin
      xa[2] = 3'd1;
      want(0, K_MIS, 0, 32'b0100, "lane2_mismatch");
      apply();
    end
    xa[2] = '0;
    want(0, K_MIS, 0, 0, "lane2_mismatch_end");
    want(0, K_CNT, 2, 3, "lane2_count");
    want(0, K_CNT, 1, 0, "lane1_count_idle");
    want(0, K_STK, 0, 32'b0100, "lane2_sticky");
    apply();

    for (int k = 0; k < 20; k++) begin
      xa[0] = 3'd1;
      want(0, K_CNT, 0, (k + 1 > 15) ? 15 : k + 1, "lane0_sat_count");
      apply();
    end
    xa[0] = '0;
    want(0, K_CNT, 0, 15, "lane0_no_wrap");
    want(0, K_CNT, 2, 3, "lane2_count_hold");
    want(0, K_STK, 0, 32'b0101, "sticky_0_2");
    apply();

    // Clear beats a simultaneous lane 1 mismatch.
    xa[1] = 3'd1; clr_a = 1'b1;
    want(0, K_CNT, 1, 0, "clear_cnt1");
    want(0, K_CNT, 0, 0, "clear_cnt0");
    want(0, K_STK, 0, 0, "clear_sticky");
    want(0, K_MIS, 0, 0, "clear_mismatch");
    want(0, K_ARM, 0, 0, "clear_armed");
    apply();
    xa[1] = '0; clr_a = 1'b0;
    want(0, K_ARM, 0, 0, "clear_flush1");
    apply();
    want(0, K_ARM, 0, 1, "clear_rearm");
    apply();

    en = 1'b0; xa[1] = 3'd1;
    want(0, K_MIS, 0, 0, "disabled_mismatch");
    want(0, K_CNT, 1, 0, "disabled_cnt1");
    want(0, K_STK, 0, 0, "disabled_sticky");
    apply();
    en = 1'b1; xa[1] = '0;

    xa[3] = 3'd1;
    want(0, K_MIS, 0, 32'b1000, "lane3_mismatch");
    want(0, K_CNT, 3, 1, "lane3_count");
    apply();
    rst_a = 1'b1;
    want(0, K_CNT, 3, 0, "rst_cnt3");
    want(0, K_STK, 0, 0, "rst_sticky");
    want(0, K_MIS, 0, 0, "rst_mismatch");
    want(0, K_ARM, 0, 0, "rst_armed");
    apply();
    rst_a = 1'b0; xa[3] = '0;
    want(0, K_ARM, 0, 0, "rst_flush1");
    apply();
    want(0, K_ARM, 0, 1, "rst_rearm");
    apply();

    // Stop-on-error instance: lane 3 corrupted on steps 10 and 11.
    rst_b = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      xb[3] = (k == 10 || k == 11) ? 3'd1 : 3'd0;
      if (k == 1) want(1, K_ARM, 0, 0, "b_flush");
      if (k == 2) want(1, K_ARM, 0, 1, "b_armed");
      if (k < 10) begin
        want(1, K_HLT, 0, 0, "b_not_halted");
        want(1, K_MIS, 0, 0, "b_clean");
      end else begin
        want(1, K_HLT, 0, 1, "b_halted");
        want(1, K_MIS, 0, 32'b1000, "b_mismatch_held");
        want(1, K_CNT, 3, 1, "b_cnt3_frozen");
      end
      apply();
    end
    xb[3] = '0;
    want(1, K_STK, 0, 32'b1000, "b_sticky");
    want(1, K_HLT, 0, 1, "b_still_halted");
    apply();
    clr_b = 1'b1;
    want(1, K_HLT, 0, 0, "b_clear_halted");
    want(1, K_CNT, 3, 0, "b_clear_cnt3");
    want(1, K_STK, 0, 0, "b_clear_sticky");
    want(1, K_ARM, 0, 0, "b_clear_armed");
    apply();
    clr_b = 1'b0;
    want(1, K_ARM, 0, 0, "b_flush_again");
    apply();
    want(1, K_ARM, 0, 1, "b_rearmed");
    apply();
    xb[3] = 3'd1;
    want(1, K_HLT, 0, 1, "b_halt_again");
    want(1, K_CNT, 3, 1, "b_cnt3_again");
    apply();
    xb[3] = '0;

    for (int t = 0; t < 10 && sb.size() > 0; t++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      errors += sb.size();
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
